// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the D-stage hazard scoreboard.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package hazard_scoreboard_pkg;

  // GPR number width (destination and source register fields).
  localparam int A3_W = 5;

  // Forwarding source encoding: 0 reads the register file, k forwards from entry k-1.
  localparam int FWD_GRF = 0;

  // Stall request sources, used as bit positions of the request vector.
  typedef enum logic [1:0] {
    REQ_RAW  = 2'd0,
    REQ_HILO = 2'd1,
    REQ_CP0  = 2'd2
  } stall_req_e;

  localparam int NREQ = 3;

  // Width of a forwarding select for a given number of tracked stages.
  function automatic int sel_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  // The "source not used" Tuse code is all ones at the given field width;
  // it can never be below a tnew, so an unused source never stalls.
  function automatic int tuse_none(input int tw);
    return (1 << tw) - 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue/D-stage bundle between the decode pipeline and the hazard scoreboard.
// Latency: n/a (wires only).
// Backpressure: stall freezes F/D and turns the issue into a bubble.
interface hazard_scoreboard_if #(
  parameter int STAGES = 3,
  parameter int NREAD  = 2,
  parameter int TW     = 3
);
  import hazard_scoreboard_pkg::*;

  localparam int SW = sel_width(STAGES);

  logic                    issue_valid;
  logic                    issue_we;
  logic [A3_W-1:0]         issue_a3;
  logic [TW-1:0]           issue_tnew;
  logic                    issue_mtc0;
  logic                    issue_eret;
  logic [STAGES-1:0]       flush_mask;
  logic [NREAD*A3_W-1:0]   rd_addr;
  logic [NREAD*TW-1:0]     rd_tuse;
  logic                    d_hilo;
  logic                    d_eret;
  logic                    md_busy;
  logic                    stall;
  logic [NREAD*SW-1:0]     fwd_sel;
  logic [31:0]             stall_cnt;

  modport master (
    output issue_valid, issue_we, issue_a3, issue_tnew, issue_mtc0, issue_eret,
    output flush_mask, rd_addr, rd_tuse, d_hilo, d_eret, md_busy,
    input  stall, fwd_sel, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_we, issue_a3, issue_tnew, issue_mtc0, issue_eret,
    input  flush_mask, rd_addr, rd_tuse, d_hilo, d_eret, md_busy,
    output stall, fwd_sel, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_hz_match.sv
// One D-stage read port compared against every in-flight entry, youngest match wins.
// Latency: combinational.
// Backpressure: none; pure lookup.
module hz_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int TW     = 3,
  parameter int SW     = sel_width(STAGES)
) (
  input  logic [STAGES-1:0]            live,
  input  logic [STAGES-1:0][A3_W-1:0]  a3,
  input  logic [STAGES-1:0][TW-1:0]    tnew,
  input  logic [A3_W-1:0]              rd_addr,
  output logic                         hit,
  output logic [SW-1:0]                idx,
  output logic [TW-1:0]                hit_tnew
);

  // Scan oldest to youngest so the lowest-index live match is the one left standing.
  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    hit_tnew = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (live[i] && (a3[i] == rd_addr)) begin
        hit      = 1'b1;
        idx      = SW'(i);
        hit_tnew = tnew[i];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard: tracks in-flight writers, drives stall and forwarding selects.
// Latency: stall/fwd_sel are combinational from state and D inputs; entries advance each clock.
// Backpressure: stall blocks the issue (bubble into E); flushed entries lose their valid bit.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int NREAD  = 2,
  parameter int TW     = 3
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave bus
);

  localparam int SW = sel_width(STAGES);
  // Only the two youngest entries can hold an mtc0 that an eret in D must wait for.
  localparam int CP0_DEPTH = (STAGES < 2) ? STAGES : 2;

  logic [STAGES-1:0]            e_valid;
  logic [STAGES-1:0]            e_we;
  logic [STAGES-1:0]            e_mtc0;
  logic [STAGES-1:0]            e_eret;
  logic [STAGES-1:0][A3_W-1:0]  e_a3;
  logic [STAGES-1:0][TW-1:0]    e_tnew;
  logic [STAGES-1:0]            e_live;

  logic [NREAD-1:0]             p_hit;
  logic [NREAD-1:0][SW-1:0]     p_idx;
  logic [NREAD-1:0][TW-1:0]     p_tnew;

  logic [NREQ-1:0]              req;
  logic                         stall_w;
  logic                         issue_take;
  logic [31:0]                  cnt;

  // Writers to $0 or non-writers never create a dependency.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      e_live[i] = e_valid[i] & e_we[i] & (e_a3[i] != '0);
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    hz_match #(
      .STAGES (STAGES),
      .TW     (TW),
      .SW     (SW)
    ) u_match (
      .live     (e_live),
      .a3       (e_a3),
      .tnew     (e_tnew),
      .rd_addr  (bus.rd_addr[p*A3_W +: A3_W]),
      .hit      (p_hit[p]),
      .idx      (p_idx[p]),
      .hit_tnew (p_tnew[p])
    );
  end

  // Collect stall requests and forwarding selects; an eret already in E overrides any stall,
  // and reset forces stall low since the D-side requests are not cleared by it.
  always_comb begin
    req     = '0;
    bus.fwd_sel = '0;
    for (int p = 0; p < NREAD; p++) begin
      if (p_hit[p] && (bus.rd_tuse[p*TW +: TW] < p_tnew[p])) begin
        req[REQ_RAW] = 1'b1;
      end
      if (p_hit[p] && (p_tnew[p] == '0)) begin
        bus.fwd_sel[p*SW +: SW] = p_idx[p] + 1'b1;
      end else begin
        bus.fwd_sel[p*SW +: SW] = SW'(FWD_GRF);
      end
    end
    req[REQ_HILO] = bus.d_hilo & bus.md_busy;
    for (int k = 0; k < CP0_DEPTH; k++) begin
      if (bus.d_eret && e_valid[k] && e_mtc0[k]) begin
        req[REQ_CP0] = 1'b1;
      end
    end
    stall_w = (|req) & ~(e_valid[0] & e_eret[0]) & ~reset;
  end

  assign bus.stall = stall_w;
  assign issue_take = bus.issue_valid & ~stall_w & ~bus.flush_mask[0];

  // Advance the in-flight pipeline: new issue (or bubble) into entry 0, older entries shift
  // with tnew counting down to 0; the oldest entry falls off into the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid <= '0;
      e_we    <= '0;
      e_mtc0  <= '0;
      e_eret  <= '0;
      e_a3    <= '0;
      e_tnew  <= '0;
    end else begin
      e_valid[0] <= issue_take;
      e_we[0]    <= bus.issue_we;
      e_mtc0[0]  <= bus.issue_mtc0;
      e_eret[0]  <= bus.issue_eret;
      e_a3[0]    <= bus.issue_a3;
      e_tnew[0]  <= bus.issue_tnew;
      for (int i = 1; i < STAGES; i++) begin
        e_valid[i] <= e_valid[i-1] & ~bus.flush_mask[i-1];
        e_we[i]    <= e_we[i-1];
        e_mtc0[i]  <= e_mtc0[i-1];
        e_eret[i]  <= e_eret[i-1];
        e_a3[i]    <= e_a3[i-1];
        e_tnew[i]  <= (e_tnew[i-1] == '0) ? '0 : e_tnew[i-1] - 1'b1;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (stall_w && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = cnt;

endmodule
